// File: rtl/dmi_tl_pkg.sv
// Shared constants and types for the DMI-to-TileLink sequencer: TL opcodes, DMI ops, response codes, FSM states.
// Pure declarations; no logic, no latency, no backpressure of its own.
package dmi_tl_pkg;

    localparam logic [2:0] TL_GET       = 3'd4;
    localparam logic [2:0] TL_PUTFULL   = 3'd0;
    localparam logic [1:0] TL_SIZE_WORD = 2'd2;
    localparam logic [3:0] TL_MASK_WORD = 4'hF;

    typedef enum logic [1:0] {
        DMI_NOP   = 2'd0,
        DMI_READ  = 2'd1,
        DMI_WRITE = 2'd2,
        DMI_RSVD  = 2'd3
    } dmi_op_e;

    typedef enum logic [1:0] {
        RESP_OK     = 2'd0,
        RESP_FAILED = 2'd2,
        RESP_BUSY   = 2'd3
    } dmi_resp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT,
        ST_RESP
    } seq_state_e;

endpackage

// File: rtl/dmi_tl_timeout.sv
// Saturating wait counter with synchronous clear; expired_o fires in the MAX-th enabled cycle after a clear.
// Single-cycle update; expiry is gated by en_i, so the caller decides what counts as a waiting cycle.
module dmi_tl_timeout #(
    parameter int unsigned MAX = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CW = (MAX < 2) ? 1 : $clog2(MAX + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CW'(MAX))) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q counts completed empty cycles, so the current cycle is number cnt_q+1.
    assign expired_o = en_i && (cnt_q >= CW'(MAX - 1));

endmodule

// File: rtl/dmi_tl_sequencer.sv
// Turns DMI read/write requests into single TL-UL Get/PutFull beats; read latency 3 cycles from acceptance.
// One A transaction in flight; D waits are bounded by TIMEOUT, and a late D beat is drained before new requests.
module dmi_tl_sequencer
    import dmi_tl_pkg::*;
#(
    parameter int          ADDR_W  = 7,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_data,
    output logic [1:0]        resp_code,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [2:0]        a_opcode,
    output logic [1:0]        a_size,
    output logic [3:0]        a_mask,
    output logic [ADDR_W+1:0] a_address,
    output logic [31:0]       a_data,
    input  logic              d_valid,
    output logic              d_ready,
    input  logic [31:0]       d_data,
    input  logic              d_denied,
    input  logic              d_corrupt
);

    seq_state_e        state_q;
    dmi_op_e           op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       resp_data_q;
    dmi_resp_e         resp_code_q;
    logic              stale_q;
    logic              send_st;
    logic              d_err;
    logic              tmo_expired;

    assign send_st = (state_q == ST_SEND);
    assign d_err   = d_denied | d_corrupt;

    dmi_tl_timeout #(.MAX(TIMEOUT)) u_timeout (
        .clock     (clock),
        .reset     (reset),
        .clr_i     (send_st && a_ready),
        .en_i      ((state_q == ST_WAIT) && !d_valid),
        .expired_o (tmo_expired)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            op_q        <= DMI_NOP;
            addr_q      <= '0;
            data_q      <= '0;
            resp_data_q <= '0;
            resp_code_q <= RESP_OK;
            stale_q     <= 1'b0;
        end else begin
            // The abandoned request's D beat may turn up in any state.
            if (stale_q && d_valid) begin
                stale_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        op_q   <= dmi_op_e'(req_op);
                        addr_q <= req_addr;
                        data_q <= req_data;
                        case (dmi_op_e'(req_op))
                            DMI_READ, DMI_WRITE: state_q <= ST_SEND;
                            DMI_NOP: begin
                                state_q     <= ST_RESP;
                                resp_code_q <= RESP_OK;
                                resp_data_q <= '0;
                            end
                            default: begin
                                state_q     <= ST_RESP;
                                resp_code_q <= RESP_FAILED;
                                resp_data_q <= '0;
                            end
                        endcase
                    end
                end
                ST_SEND: begin
                    if (a_ready) begin
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (d_valid) begin
                        state_q     <= ST_RESP;
                        resp_code_q <= d_err ? RESP_FAILED : RESP_OK;
                        resp_data_q <= (op_q == DMI_READ && !d_err) ? d_data : 32'd0;
                    end else if (tmo_expired) begin
                        state_q     <= ST_RESP;
                        resp_code_q <= RESP_BUSY;
                        resp_data_q <= '0;
                        stale_q     <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_q     <= ST_IDLE;
                        resp_code_q <= RESP_OK;
                        resp_data_q <= '0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE) && !stale_q;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_data  = resp_data_q;
    assign resp_code  = resp_code_q;
    assign d_ready    = (state_q == ST_WAIT) || stale_q;

    // A fields are decoded from captured registers, so they cannot move during an A stall.
    assign a_valid   = send_st;
    assign a_opcode  = !send_st ? 3'd0 : ((op_q == DMI_READ) ? TL_GET : TL_PUTFULL);
    assign a_size    = send_st ? TL_SIZE_WORD : 2'd0;
    assign a_mask    = send_st ? TL_MASK_WORD : 4'h0;
    assign a_address = send_st ? {addr_q, 2'b00} : '0;
    assign a_data    = (send_st && op_q == DMI_WRITE) ? data_q : 32'd0;

endmodule

// File: tb/tb_dmi_tl_sequencer.sv
// Bench for dmi_tl_sequencer: directed corner cases then random DMI transactions, with the bench acting as TL slave.
// Expected A beats and responses come from a transaction-level model of the DMI/TL rules.
module tb_dmi_tl_sequencer;

    localparam int TMO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [6:0]  req_addr;
    logic [31:0] req_data;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;
    logic        a_valid;
    logic        a_ready;
    logic [2:0]  a_opcode;
    logic [1:0]  a_size;
    logic [3:0]  a_mask;
    logic [8:0]  a_address;
    logic [31:0] a_data;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_data;
    logic        d_denied;
    logic        d_corrupt;

    int n_checks = 0;
    int n_errors = 0;

    dmi_tl_sequencer #(.ADDR_W(7), .TIMEOUT(TMO)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_code  (resp_code),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_opcode   (a_opcode),
        .a_size     (a_size),
        .a_mask     (a_mask),
        .a_address  (a_address),
        .a_data     (a_data),
        .d_valid    (d_valid),
        .d_ready    (d_ready),
        .d_data     (d_data),
        .d_denied   (d_denied),
        .d_corrupt  (d_corrupt)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check_eq({tag, "_a_valid"}, 64'(a_valid), 64'd0);
        check_eq({tag, "_d_ready"}, 64'(d_ready), 64'd0);
        check_eq({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check_eq({tag, "_resp_data"}, 64'(resp_data), 64'd0);
        check_eq({tag, "_resp_code"}, 64'(resp_code), 64'd0);
        check_eq({tag, "_a_fields"}, {21'd0, a_opcode, a_size, a_mask, a_address, a_data}, 64'd0);
    endtask

    // One DMI transaction. a_dly: A stall cycles; d_dly: empty WAIT cycles before the D beat
    // (d_dly >= TMO means the slave answers only after the sequencer has given up).
    task automatic do_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] wdata,
                          input int a_dly, input int d_dly, input logic den, input logic cor,
                          input logic [31:0] rdata, input int r_dly);
        logic        is_acc;
        logic        timed_out;
        logic [1:0]  exp_code;
        logic [31:0] exp_data;
        int          n_wait;

        is_acc    = (op == 2'd1) || (op == 2'd2);
        timed_out = is_acc && (d_dly >= TMO);
        exp_data  = 32'd0;
        if (op == 2'd0)          exp_code = 2'd0;
        else if (op == 2'd3)     exp_code = 2'd2;
        else if (timed_out)      exp_code = 2'd3;
        else if (den || cor)     exp_code = 2'd2;
        else begin
            exp_code = 2'd0;
            if (op == 2'd1) exp_data = rdata;
        end

        check_eq("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_data  = wdata;
        step();
        req_valid = 1'b0;
        req_op    = 2'($urandom);
        req_addr  = 7'($urandom);
        req_data  = $urandom;

        if (is_acc) begin
            for (int i = 0; i <= a_dly; i++) begin
                check_eq("a_valid", 64'(a_valid), 64'd1);
                check_eq("a_opcode", 64'(a_opcode), (op == 2'd1) ? 64'd4 : 64'd0);
                check_eq("a_size_mask", {58'd0, a_size, a_mask}, {58'd0, 2'd2, 4'hF});
                check_eq("a_address", 64'(a_address), 64'(addr) * 64'd4);
                check_eq("a_data", 64'(a_data), (op == 2'd2) ? 64'(wdata) : 64'd0);
                check_eq("req_ready_busy", 64'(req_ready), 64'd0);
                a_ready = (i == a_dly);
                step();
            end
            a_ready = 1'b0;
            check_eq("a_single_beat", 64'(a_valid), 64'd0);
            n_wait = timed_out ? TMO : d_dly + 1;
            for (int w = 1; w <= n_wait; w++) begin
                check_eq("d_ready_wait", 64'(d_ready), 64'd1);
                check_eq("resp_valid_wait", 64'(resp_valid), 64'd0);
                if (!timed_out && w == n_wait) begin
                    d_valid   = 1'b1;
                    d_data    = rdata;
                    d_denied  = den;
                    d_corrupt = cor;
                end
                step();
                d_valid   = 1'b0;
                d_denied  = 1'b0;
                d_corrupt = 1'b0;
                d_data    = $urandom;
            end
        end else begin
            check_eq("no_a_beat", 64'(a_valid), 64'd0);
        end

        for (int i = 0; i <= r_dly; i++) begin
            check_eq("resp_valid", 64'(resp_valid), 64'd1);
            check_eq("resp_code", 64'(resp_code), 64'(exp_code));
            check_eq("resp_data", 64'(resp_data), 64'(exp_data));
            check_eq("a_valid_resp", 64'(a_valid), 64'd0);
            if (timed_out) check_eq("d_ready_stale_resp", 64'(d_ready), 64'd1);
            resp_ready = (i == r_dly);
            step();
        end
        resp_ready = 1'b0;
        check_eq("resp_done", 64'(resp_valid), 64'd0);

        if (timed_out) begin
            for (int i = 0; i < 2; i++) begin
                check_eq("stale_blocks_req", 64'(req_ready), 64'd0);
                check_eq("d_ready_stale_idle", 64'(d_ready), 64'd1);
                step();
            end
            d_valid = 1'b1;
            d_data  = $urandom;
            step();
            d_valid = 1'b0;
            check_eq("stale_cleared", 64'(req_ready), 64'd1);
            check_eq("late_beat_no_resp", 64'(resp_valid), 64'd0);
            check_eq("d_ready_after_stale", 64'(d_ready), 64'd0);
        end else begin
            check_eq("req_ready_back", 64'(req_ready), 64'd1);
        end
    endtask

    task automatic reset_in_wait();
        check_eq("rst_req_ready", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_op    = 2'd1;
        req_addr  = 7'h2A;
        step();
        req_valid = 1'b0;
        a_ready   = 1'b1;
        step();
        a_ready = 1'b0;
        check_eq("rst_in_wait", 64'(d_ready), 64'd1);
        #1 reset = 1'b1;
        #1;
        check_idle_outputs("rst_async");
        step();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            d_valid = (i == 1);
            d_data  = 32'hCAFEF00D;
            step();
            check_eq("rst_no_resp", 64'(resp_valid), 64'd0);
        end
        d_valid = 1'b0;
        check_idle_outputs("rst_after");
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_op     = 2'd0;
        req_addr   = 7'd0;
        req_data   = 32'd0;
        resp_ready = 1'b0;
        a_ready    = 1'b0;
        d_valid    = 1'b0;
        d_data     = 32'd0;
        d_denied   = 1'b0;
        d_corrupt  = 1'b0;
        step();
        step();
        check_idle_outputs("reset");
        reset = 1'b0;
        step();
        check_idle_outputs("post_reset");

        do_txn(2'd1, 7'h11, 32'd0, 0, 0, 1'b0, 1'b0, 32'hDEADBEEF, 0);
        do_txn(2'd2, 7'h05, 32'h12345678, 3, 1, 1'b0, 1'b0, 32'hFFFFFFFF, 1);
        do_txn(2'd1, 7'h22, 32'd0, 0, 2, 1'b1, 1'b0, 32'h55AA55AA, 0);
        do_txn(2'd1, 7'h23, 32'd0, 1, 0, 1'b0, 1'b1, 32'h01020304, 0);
        do_txn(2'd3, 7'h7F, 32'hA5A5A5A5, 0, 0, 1'b0, 1'b0, 32'd0, 2);
        do_txn(2'd0, 7'h01, 32'hFFFFFFFF, 0, 0, 1'b0, 1'b0, 32'd0, 0);
        do_txn(2'd1, 7'h33, 32'd0, 0, TMO, 1'b0, 1'b0, 32'h11111111, 1);
        do_txn(2'd1, 7'h34, 32'd0, 0, TMO - 1, 1'b0, 1'b0, 32'h87654321, 0);
        do_txn(2'd2, 7'h7F, 32'h0BADF00D, 2, TMO + 3, 1'b0, 1'b0, 32'd0, 0);
        reset_in_wait();

        for (int t = 0; t < 80; t++) begin
            do_txn(2'($urandom), 7'($urandom), $urandom,
                   int'($urandom_range(3, 0)), int'($urandom_range(TMO + 2, 0)),
                   ($urandom_range(7, 0) == 0), ($urandom_range(7, 0) == 0),
                   $urandom, int'($urandom_range(2, 0)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
